// File: rtl/pipelined_rc_adder_if.sv
// Operand/result bundle for pipelined_rc_adder; the ovf signal exists only
// when PIPELINED_RC_ADDER_OVF_EN is defined.
interface pipelined_rc_adder_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             carry;
`ifdef PIPELINED_RC_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output en, in_valid, a, b, cin,
        input  out_valid, s, carry
`ifdef PIPELINED_RC_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  en, in_valid, a, b, cin,
        output out_valid, s, carry
`ifdef PIPELINED_RC_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES chunks, one chunk per stage.
// Optional signed-overflow output under macro PIPELINED_RC_ADDER_OVF_EN.
module pipelined_rc_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst_n,
    pipelined_rc_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_rc_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Stage k owns sum bits [0 +: (k+1)*CHUNK] and the still-unused operand bits above its chunk.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = (k + 1) * CHUNK;

        logic [CHUNK-1:0] a_c;
        logic [CHUNK-1:0] b_c;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   add_w;
        logic [SW-1:0]    s_d;
        logic [SW-1:0]    s_q;
        logic             carry_q;
        logic             vld_q;

        if (k == 0) begin : g_head
            assign a_c  = bus.a[CHUNK-1:0];
            assign b_c  = bus.b[CHUNK-1:0];
            assign c_in = bus.cin;
            assign v_in = bus.in_valid;
            assign s_d  = add_w[CHUNK-1:0];
        end else begin : g_tail
            assign a_c  = g_stage[k-1].g_fwd.a_hi_q[CHUNK-1:0];
            assign b_c  = g_stage[k-1].g_fwd.b_hi_q[CHUNK-1:0];
            assign c_in = g_stage[k-1].carry_q;
            assign v_in = g_stage[k-1].vld_q;
            assign s_d  = {add_w[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign add_w = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, c_in};

        // NOTE: sequential state uses non-blocking assignment so every stage samples the
        // previous stage's old value on the same edge; blocking here would collapse the pipe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q     <= '0;
                carry_q <= 1'b0;
                vld_q   <= 1'b0;
            end else if (bus.en) begin
                s_q     <= s_d;
                carry_q <= add_w[CHUNK];
                vld_q   <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int HW = WIDTH - SW;

            logic [HW-1:0] a_hi_d;
            logic [HW-1:0] b_hi_d;
            logic [HW-1:0] a_hi_q;
            logic [HW-1:0] b_hi_q;

            if (k == 0) begin : g_src_in
                assign a_hi_d = bus.a[WIDTH-1:CHUNK];
                assign b_hi_d = bus.b[WIDTH-1:CHUNK];
            end else begin : g_src_prev
                assign a_hi_d = g_stage[k-1].g_fwd.a_hi_q[HW+CHUNK-1:CHUNK];
                assign b_hi_d = g_stage[k-1].g_fwd.b_hi_q[HW+CHUNK-1:CHUNK];
            end

            // NOTE: the operand skew registers are reset like any other state so the
            // pipeline contents after reset are deterministic, not just the valid bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (bus.en) begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end
    end

    assign bus.s         = g_stage[STAGES-1].s_q;
    assign bus.carry     = g_stage[STAGES-1].carry_q;
    assign bus.out_valid = g_stage[STAGES-1].vld_q;

`ifdef PIPELINED_RC_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Last-stage chunk carries the operand MSBs; overflow when they agree and the sum MSB differs.
    assign ovf_d = (g_stage[STAGES-1].a_c[CHUNK-1] == g_stage[STAGES-1].b_c[CHUNK-1]) &&
                   (g_stage[STAGES-1].add_w[CHUNK-1] != g_stage[STAGES-1].a_c[CHUNK-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.en) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: doc/pipelined_rc_adder.md
Name: pipelined_rc_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add of a + b + cin into STAGES equal chunks, one per register stage; carry passes between stages.
- Gives throughput of one add per clock, with a valid tag and a global stall.
- Drop-in arithmetic unit for datapaths where a full-width ripple chain misses timing.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- STAGES, 4, number of pipeline stages. WIDTH % STAGES must equal 0; otherwise elaboration fails with a generate-time error.
- CHUNK, WIDTH/STAGES, derived local parameter, not overridable: bits added per stage.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  pipeline advance enable; 0 = stall, all stage registers hold.
- in_valid  input  1  a/b/cin are a valid operation this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry in to bit 0.
- out_valid  output  1  s/carry hold a completed result.
- s  output  WIDTH  sum, registered.
- carry  output  1  carry out of bit WIDTH-1, registered.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous-to-clk deassert handled upstream):
  - out_valid=0, s=0, carry=0.
  - All internal stage registers (partial sums, carries, delayed operands, valid bits) = 0.
- Stage k (0..STAGES-1) computes chunk bits [k*CHUNK +: CHUNK] = a_chunk + b_chunk + c_k.
  - c_0 = cin; c_k = registered carry out of stage k-1.
  - Sum-chunk and carry-out are registered at the end of stage k.
- Operand skew:
  - Chunks k>0 of a and b are delayed k cycles through shift registers so they meet c_k.
  - Completed low sum chunks are delayed (de-skewed) so all chunks of s appear in the same cycle.
- Latency: exactly STAGES enabled clock edges from in_valid=1 sampled to out_valid=1 with the matching s/carry. STAGES=1 degenerates to a single registered WIDTH-bit adder with latency 1.
- Throughput: one operation per enabled cycle; back-to-back in_valid=1 produce back-to-back out_valid=1.
- Valid propagation:
  - A STAGES-deep valid shift register advances only when en=1. out_valid is its last bit.
  - Data registers advance on en=1 regardless of in_valid; s/carry are don't-care-but-deterministic when out_valid=0.
- Stall (en=0):
  - Every register holds, including out_valid, s and carry.
  - Inputs presented during a stall are ignored (not captured).
- Arithmetic:
  - Unsigned modulo-2^WIDTH sum; {carry,s} = a + b + cin exactly.
  - All-ones + 1 wraps: s=0, carry=1, with the carry rippling through all stages.
- Reset mid-operation: every in-flight operation is discarded; no out_valid pulse for any operation accepted before reset.
- Simultaneous en=0 and in_valid=1: input not accepted, no result generated for it.

Optional Feature:
- Macro: PIPELINED_RC_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0), aligned with out_valid.
  - ovf = two's-complement signed overflow of a + b + cin: operand MSBs equal and sum MSB different.
  - Computed in the last stage from the delayed operand MSBs and the final sum MSB.
- Undefined: no ovf port; no extra logic.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Reset, then a=16'h1234, b=16'h1111, cin=0, in_valid=1 for one cycle, en=1 -> out_valid high exactly 4 cycles later for 1 cycle, s=16'h2345, carry=0.
- a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, carry=1 (full cross-stage carry ripple).
- 10 back-to-back random ops with in_valid=1 -> 10 consecutive out_valid cycles, each {carry,s} == a+b+cin of the op issued 4 cycles earlier (scoreboard).
- Issue 3 ops, drop en=0 for 5 cycles mid-flight, inputs toggling with in_valid=1 during the stall -> outputs frozen during the stall; exactly 3 results emerge after en=1, correct and in order; stalled inputs never appear.
- Issue 2 ops, assert rst_n=0 asynchronously between clock edges -> out_valid, s and carry go to 0 immediately; after release, no out_valid until a new op completes.
- With PIPELINED_RC_ADDER_OVF_EN defined: a=16'h7FFF, b=16'h0001, cin=0 -> s=16'h8000, carry=0, ovf=1. Then a=16'h8000, b=16'hFFFF, cin=0 -> s=16'h7FFF, carry=1, ovf=1. With STAGES=1, the first case gives latency 1.
